// File: rtl/fp_pkg.sv
// Shared widths, FSM states and flag bit positions for the normalise/round/pack stage.
package fp_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 23;
  localparam int FRAC_W   = 32;
  localparam int EXP_W    = 10;

  localparam int FLG_OVF     = 3;
  localparam int FLG_UNF     = 2;
  localparam int FLG_ZERO    = 1;
  localparam int FLG_INEXACT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } norm_state_t;
endpackage

// File: rtl/fp_normalise_round_if.sv
// Upstream (raw adder result) and downstream (packed word) handshakes of the stage.
interface fp_normalise_round_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [7:0]        in_exp;
  logic [FRAC_W-1:0] in_frac;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [3:0]        out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_frac, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_normalise_round_round.sv
// Mantissa rounder: round-to-nearest-even when FP_NORM_ROUND_RNE_EN is defined,
// otherwise plain truncation with no carry path.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W:0] mant_i,
  input  logic            guard_i,
  input  logic            sticky_i,
  output logic [MANT_W:0] mant_o,
  output logic            carry_o
);
`ifdef FP_NORM_ROUND_RNE_EN
  logic [MANT_W+1:0] sum;
  logic              rnd_up;

  assign rnd_up  = guard_i & (sticky_i | mant_i[0]);
  assign sum     = {1'b0, mant_i} + {{(MANT_W+1){1'b0}}, rnd_up};
  assign mant_o  = sum[MANT_W:0];
  assign carry_o = sum[MANT_W+1];
`else
  logic unused_gs;

  assign unused_gs = guard_i ^ sticky_i;
  assign mant_o    = mant_i;
  assign carry_o   = 1'b0;
`endif
endmodule

// File: rtl/fp_normalise_round.sv
// Bit-serial normalise, round and pack of the FP adder result into IEEE-754 single.
// Rounding mode is selected by FP_NORM_ROUND_RNE_EN (see fp_round_rne).
module fp_normalise_round
  import fp_pkg::*;
(
  input logic clk,
  input logic rst_n,
  fp_normalise_round_if.slave bus
);
  localparam logic signed [EXP_W-1:0] EXP_OVF = EXP_W'(EXP_MAX);

  norm_state_t              state_q;
  logic                     sign_q;
  logic signed [EXP_W-1:0]  exp_q;
  logic [FRAC_W-1:0]        frac_q;
  logic                     guard_q, sticky_q;
  logic [31:0]              result_q, result_d;
  logic [3:0]               flags_q, flags_d;
  logic                     out_valid_q, in_ready_q;

  logic [MANT_W:0]          rnd_mant;
  logic                     rnd_carry;
  logic signed [EXP_W-1:0]  exp_r;
  logic [MANT_W-1:0]        mant_r;

  fp_round_rne u_round (
    .mant_i   (frac_q[MANT_W:0]),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .mant_o   (rnd_mant),
    .carry_o  (rnd_carry)
  );

  // A rounding carry renormalises by one right shift in the same cycle.
  always_comb begin
    exp_r    = exp_q + EXP_W'(rnd_carry);
    mant_r   = rnd_carry ? rnd_mant[MANT_W:1] : rnd_mant[MANT_W-1:0];
    flags_d  = '0;
    flags_d[FLG_INEXACT] = guard_q | sticky_q;
    result_d = {sign_q, exp_r[7:0], mant_r};
    if (!exp_r[EXP_W-1] && exp_r >= EXP_OVF) begin
      result_d = {sign_q, 8'hFF, 23'd0};
      flags_d[FLG_OVF] = 1'b1;
    end else if (exp_r[EXP_W-1] || exp_r == '0) begin
      result_d = {sign_q, 31'd0};
      flags_d[FLG_UNF]  = 1'b1;
      flags_d[FLG_ZERO] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      frac_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          sign_q     <= bus.in_sign;
          exp_q      <= {2'b00, bus.in_exp};
          frac_q     <= bus.in_frac;
          guard_q    <= 1'b0;
          sticky_q   <= 1'b0;
          in_ready_q <= 1'b0;
          state_q    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (frac_q == '0) begin
            result_q    <= '0;
            flags_q     <= 4'b0001 << FLG_ZERO;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else if (|frac_q[FRAC_W-1:MANT_W+1]) begin
            frac_q   <= frac_q >> 1;
            exp_q    <= exp_q + 10'sd1;
            guard_q  <= frac_q[0];
            sticky_q <= sticky_q | guard_q;
          end else if (!frac_q[MANT_W]) begin
            frac_q <= frac_q << 1;
            exp_q  <= exp_q - 10'sd1;
          end else begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          result_q    <= result_d;
          flags_q     <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;
endmodule

// File: doc/fp_normalise_round.md
# fp_normalise_round

Sequential normalise/round/pack stage that sits directly downstream of the floating-point adder datapath. It accepts the adder's raw result over a valid/ready handshake: sign, larger exponent, and an unnormalised 32-bit fraction with the hidden bit at position 23. It normalises the fraction one bit per cycle, rounds, handles exponent overflow and underflow, and emits a packed IEEE-754 single-precision word with status flags. It replaces the unbounded combinational normalise loop with a bounded, synthesizable FSM.

## Interface
- No parameters; widths come from `fp_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream result valid.
- `in_ready` out 1: stage can accept.
- `in_sign` in 1: result sign.
- `in_exp` in 8: biased exponent of the larger operand.
- `in_frac` in 32: unnormalised magnitude. Normalised when `[31:24]==0` and `[23]==1`.
- `out_valid` out 1: packed result available.
- `out_ready` in 1: downstream accepts.
- `out_result` out 32: `{sign, exp[7:0], mant[22:0]}`.
- `out_flags` out 4: `{overflow, underflow, zero, inexact}`.

## Operation
- States: IDLE, SHIFT, ROUND, OUT. `in_ready` = (state==IDLE).
- Accept (`in_valid && in_ready`):
  - Capture sign and frac.
  - Capture exponent into a 10-bit signed working register.
  - Clear guard and sticky.
  - Go to SHIFT.
- SHIFT, one action per cycle:
  - frac==0 → OUT with result `0x00000000` (always +0) and `zero=1`.
  - `frac[31:24]!=0` → shift right 1, exp+1. The old guard ORs into sticky; the shifted-out bit becomes guard.
  - `frac[23]==0` → shift left 1, exp−1, shifting in zero.
  - Otherwise → ROUND.
- ROUND:
  - Round the 24-bit mantissa using guard/sticky (see Configuration).
  - A rounding carry to `0x1000000` → shift right 1, exp+1, in the same cycle.
  - exp ≥ 255 → `{sign, 8'hFF, 23'd0}`, `overflow=1`.
  - exp ≤ 0 → `{sign, 31'd0}`, `underflow=1`, `zero=1`. Denormals are flushed.
  - `inexact` = guard|sticky (before rounding).
  - Register the result and go to OUT.
- OUT:
  - Hold `out_valid` high; `out_result` and `out_flags` stay stable until `out_ready`.
  - On `out_valid && out_ready` → IDLE.
  - A new input is not accepted in the same cycle; `in_ready` rises the next cycle.
- Bounded shifts: at most 8 right or 23 left per operation.

## Timing
- Reset, asynchronous and immediate (including mid-SHIFT or mid-OUT):
  - state=IDLE
  - `in_ready=1`
  - `out_valid=0`
  - `out_result=0`
  - `out_flags=0`
  - all working registers 0
- Latency for n shifts: `out_valid` rises n+2 edges after the accepting edge.
- Zero fraction: `out_valid` rises 1 edge after acceptance.
- Throughput: one result per n+3 cycles minimum. No pipelining.
- All outputs are registered. No combinational path from `in_*` to `out_*`.

## Configuration
- `FP_NORM_ROUND_RNE_EN`:
  - Defined: round-to-nearest-even. Round up if guard && (sticky || lsb).
  - Undefined: truncate, with no rounding carry path.
  - `inexact` is reported identically in both modes.

## Structure
- `fp_pkg` holds:
  - `EXP_BIAS=127`, `EXP_MAX=255`, `MANT_W=23`, `FRAC_W=32`
  - state enum `norm_state_t`
  - flag bit-index constants
- One sub-module, `fp_round_rne`: combinational. Inputs: 24-bit mantissa, guard, sticky. Outputs: rounded mantissa, carry.

## Test plan
- Right shift:
  - Stimulus: sign 0, exp `0x80`, frac `0x01000000`.
  - Response: `0x40800000`, flags `0000`, `out_valid` 3 edges after accept.
- Cancellation:
  - Stimulus: sign 1, exp `0x7F`, frac `0x00000001`.
  - Response: 23 left shifts → `0xB4000000`, `out_valid` 25 edges after accept.
- Rounding:
  - Stimulus: exp `0x80`, frac `0x01FFFFFF`.
  - Response with the macro defined: `0x41000000`, inexact=1.
  - Response with the macro undefined: `0x40FFFFFF`, inexact=1.
- Boundaries:
  - exp `0xFE`, frac `0x01000000` → `0x7F800000`, overflow=1.
  - exp `0x01`, frac `0x00400000` → `0x00000000`, underflow=1, zero=1.
- Zero:
  - Stimulus: sign 1, frac 0.
  - Response: `0x00000000`, zero=1, `out_valid` 1 edge after accept.
- Backpressure and reset:
  - Hold `out_ready=0` for 5 cycles → result stable and `in_ready=0` throughout.
  - Assert `rst_n=0` mid-SHIFT → `out_valid=0` and `in_ready=1` immediately, before the next edge.
